bcd_convert_scheduler: RTL

//  Shares one iterative (1 bit/clock) shift-add-3 binary-to-BCD engine between two requesters,
//  e.g. the sonar distance path and the raw echo-count path, with round-robin arbitration.

---
 rtl/bcd_convert_scheduler_if.sv | 27 ++
 rtl/bcd_convert_scheduler.sv | 117 +++++++++++
 2 files changed

// File: rtl/bcd_convert_scheduler_if.sv
// Request/grant and result bundle between the two requesters and the shared
// binary-to-BCD conversion engine.
interface bcd_convert_scheduler_if #(
  parameter int BIN_W  = 19,
  parameter int DIGITS = 6
);
  logic                  req0;
  logic [BIN_W-1:0]      bin0;
  logic                  gnt0;
  logic                  req1;
  logic [BIN_W-1:0]      bin1;
  logic                  gnt1;
  logic                  busy;
  logic                  done;
  logic                  done_id;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (
    output req0, bin0, req1, bin1,
    input  gnt0, gnt1, busy, done, done_id, bcd_out
  );

  modport slave (
    input  req0, bin0, req1, bin1,
    output gnt0, gnt1, busy, done, done_id, bcd_out
  );
endinterface

// File: rtl/bcd_convert_scheduler.sv
// Round-robin arbiter in front of one iterative shift-add-3 binary-to-BCD engine
// that converts one operand bit per clock.
module bcd_convert_scheduler #(
  parameter int BIN_W  = 19,
  parameter int DIGITS = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bcd_convert_scheduler_if.slave   bus
);
  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, next_state;
  logic [BIN_W-1:0]  shreg;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_adj;
  logic [ACC_W-1:0]  acc_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              rr;
  logic              cur_id;
  logic              winner;
  logic              take;
  logic              finish;
  logic              gnt0, gnt1;
  logic              done_id;
  logic [ACC_W-1:0]  bcd_out;

  // Each digit >= 5 is bumped by 3 with 4-bit wrap; no carry between digits.
  function automatic logic [ACC_W-1:0] add3_digits(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign winner  = (bus.req0 & bus.req1) ? ~rr : bus.req1;
  assign acc_adj = add3_digits(acc);
  assign acc_nxt = {acc_adj[ACC_W-2:0], shreg[BIN_W-1]};

  always_comb begin
    next_state = state;
    take       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          take       = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST_SHIFT) begin
          finish     = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Control and published results; reset discards any in-flight conversion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rr      <= 1'b1;
      cur_id  <= 1'b0;
      cnt     <= '0;
      done_id <= 1'b0;
      bcd_out <= '0;
    end else begin
      gnt0 <= take & ~winner;
      gnt1 <= take & winner;
      if (take) begin
        rr     <= winner;
        cur_id <= winner;
        cnt    <= '0;
      end else if (state == SHIFT) begin
        cnt <= cnt + 1'b1;
      end
      if (finish) begin
        bcd_out <= acc_nxt;
        done_id <= cur_id;
      end
    end
  end

  // Conversion datapath: loaded on grant, shifted once per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (take) begin
      shreg <= winner ? bus.bin1 : bus.bin0;
      acc   <= '0;
    end else if (state == SHIFT) begin
      shreg <= shreg << 1;
      acc   <= acc_nxt;
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.done_id = done_id;
  assign bus.bcd_out = bcd_out;
endmodule
